// File: rtl/player_pkg.sv
// Shared types and constants for the player kinematics block.
// Positions and velocities are fixed point with FRAC fractional bits.
// The *_SUB constants are bounds on the player's centre, already converted to sub-pixels.
package player_pkg;

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    RISE     = 2'd1,
    FALL     = 2'd2
  } phys_state_t;

  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_JUMP  = 8'h52;

  localparam int FRAC        = 4;
  localparam int SIZE_X      = 28;
  localparam int SIZE_Y      = 62;
  localparam int X_MIN       = 31;
  localparam int X_MAX       = 607;
  localparam int Y_MIN       = 100;
  localparam int Y_MAX       = 451;
  localparam int FLOOR_Y     = 408;
  localparam int PLAT_L      = 116;
  localparam int PLAT_R      = 523;
  localparam int X_START     = 320;
  localparam int WALK_STEP   = 32;
  localparam int JUMP_VEL    = 128;
  localparam int JUMP_CUT    = 32;
  localparam int GRAVITY     = 8;
  localparam int MAX_FALL    = 96;
  localparam int DROP_FRAMES = 8;

  localparam int POS_W  = 10 + FRAC;
  localparam int VEL_W  = 11 + FRAC;
  localparam int SUM_W  = 12 + FRAC;
  localparam int DROP_W = 4;

  localparam int HALF_X = SIZE_X / 32'sd2;
  localparam int HALF_Y = SIZE_Y / 32'sd2;

  // Whole pixels to signed sub-pixels at the width of the position sums.
  function automatic logic signed [SUM_W-1:0] to_sub(input int px);
    return SUM_W'(px <<< FRAC);
  endfunction

  // Centre limits: the edges stay inside the arena.
  localparam logic signed [SUM_W-1:0] X_LO_SUB    = to_sub(X_MIN + HALF_X);
  localparam logic signed [SUM_W-1:0] X_HI_SUB    = to_sub(X_MAX - HALF_X);
  localparam logic signed [SUM_W-1:0] Y_TOP_SUB   = to_sub(Y_MIN + HALF_Y);
  localparam logic signed [SUM_W-1:0] Y_BOT_SUB   = to_sub(Y_MAX - HALF_Y);
  // Centre Y when the feet rest on the platform.
  localparam logic signed [SUM_W-1:0] Y_PLAT_SUB  = to_sub(FLOOR_Y - HALF_Y);
  // Centre X range over which the body overlaps the platform span.
  localparam logic signed [SUM_W-1:0] PLAT_XL_SUB = to_sub(PLAT_L - HALF_X);
  localparam logic signed [SUM_W-1:0] PLAT_XR_SUB = to_sub(PLAT_R + HALF_X);

  localparam logic signed [VEL_W-1:0] VEL_ZERO   = {VEL_W{1'b0}};
  localparam logic signed [VEL_W-1:0] WALK_V     = VEL_W'(WALK_STEP);
  localparam logic signed [VEL_W-1:0] JUMP_V     = VEL_W'(-JUMP_VEL);
  localparam logic signed [VEL_W-1:0] CUT_V      = VEL_W'(-JUMP_CUT);
  localparam logic signed [VEL_W-1:0] GRAV_V     = VEL_W'(GRAVITY);
  localparam logic signed [VEL_W-1:0] MAX_FALL_V = VEL_W'(MAX_FALL);
  localparam logic [DROP_W-1:0]       DROP_INIT  = DROP_W'(DROP_FRAMES);

endpackage

// File: rtl/player_key_decode.sv
// Keycode slot decoder: a key counts as pressed when any slot holds its code.
module player_key_decode
  import player_pkg::*;
#(
  parameter int NUM_KEYS = 2
) (
  input  logic [8*NUM_KEYS-1:0] keycode,
  output logic                  key_left,
  output logic                  key_right,
  output logic                  key_down,
  output logic                  key_jump
);

  // OR the per-slot matches for each key of interest.
  always_comb begin
    key_left  = 1'b0;
    key_right = 1'b0;
    key_down  = 1'b0;
    key_jump  = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      key_left  = key_left  | (keycode[8*i +: 8] == KEY_LEFT);
      key_right = key_right | (keycode[8*i +: 8] == KEY_RIGHT);
      key_down  = key_down  | (keycode[8*i +: 8] == KEY_DOWN);
      key_jump  = key_jump  | (keycode[8*i +: 8] == KEY_JUMP);
    end
  end

endmodule

// File: rtl/player_physics.sv
// Per-frame player kinematics: walk, jump/fall state machine, one-way platform
// with drop-through, and arena clamping. One update per frame_clk rising edge.
module player_physics
  import player_pkg::*;
#(
  parameter int NUM_KEYS = 2
) (
  input  logic                  frame_clk,
  input  logic                  Reset_n,
  input  logic [8*NUM_KEYS-1:0] keycode,
  output logic [9:0]            PlayerX,
  output logic [9:0]            PlayerY,
  output logic [9:0]            PlayerSX,
  output logic [9:0]            PlayerSY,
  output logic                  facing_left,
  output logic                  on_ground,
  output logic [1:0]            state
);

  logic key_left_s, key_right_s, key_down_s, key_jump_s;

  player_key_decode #(.NUM_KEYS(NUM_KEYS)) u_key_decode (
    .keycode   (keycode),
    .key_left  (key_left_s),
    .key_right (key_right_s),
    .key_down  (key_down_s),
    .key_jump  (key_jump_s)
  );

  phys_state_t              state_r, state_next_s;
  logic [POS_W-1:0]         x_r, y_r, x_new_s, y_new_s;
  logic signed [VEL_W-1:0]  vy_r, vy_next_s, vy_grav_s, vx_s;
  logic                     facing_left_r, facing_next_s;
  logic                     jump_armed_r, armed_next_s;
  logic [DROP_W-1:0]        drop_cnt_r, drop_next_s;
  logic signed [SUM_W-1:0]  x_ext_s, y_ext_s, x_sum_s, y_sum_s, x_new_ext_s;
  logic                     overlap_s, overlap_new_s, on_plat_s, no_support_s;

  assign x_ext_s     = $signed({{(SUM_W-POS_W){1'b0}}, x_r});
  assign y_ext_s     = $signed({{(SUM_W-POS_W){1'b0}}, y_r});
  assign x_new_ext_s = $signed({{(SUM_W-POS_W){1'b0}}, x_new_s});

  // Support tests use the position at the start of the frame; landing uses the moved X.
  assign overlap_s     = (x_ext_s >= PLAT_XL_SUB) && (x_ext_s <= PLAT_XR_SUB);
  assign overlap_new_s = (x_new_ext_s >= PLAT_XL_SUB) && (x_new_ext_s <= PLAT_XR_SUB);
  assign on_plat_s     = overlap_s && (y_ext_s == Y_PLAT_SUB);
  assign no_support_s  = !overlap_s && (y_ext_s < Y_BOT_SUB);

  // Horizontal: walk velocity from keys, facing, then move and clamp to the arena.
  always_comb begin
    vx_s          = VEL_ZERO;
    facing_next_s = facing_left_r;
    case ({key_left_s, key_right_s})
      2'b10: begin
        vx_s          = -WALK_V;
        facing_next_s = 1'b1;
      end
      2'b01: begin
        vx_s          = WALK_V;
        facing_next_s = 1'b0;
      end
      default: begin
        vx_s          = VEL_ZERO;
        facing_next_s = facing_left_r;
      end
    endcase
    x_sum_s = x_ext_s + SUM_W'(vx_s);
    if (x_sum_s < X_LO_SUB) begin
      x_new_s = X_LO_SUB[POS_W-1:0];
    end else if (x_sum_s > X_HI_SUB) begin
      x_new_s = X_HI_SUB[POS_W-1:0];
    end else begin
      x_new_s = x_sum_s[POS_W-1:0];
    end
  end

  // Vertical: jump/fall state machine, velocity, move, then ceiling/landing resolution.
  always_comb begin
    state_next_s = state_r;
    vy_next_s    = vy_r;
    armed_next_s = key_jump_s ? jump_armed_r : 1'b1;
    drop_next_s  = (drop_cnt_r == {DROP_W{1'b0}}) ? drop_cnt_r : drop_cnt_r - DROP_W'(1);
    vy_grav_s    = vy_r + GRAV_V;

    case (state_r)
      GROUNDED: begin
        vy_next_s = VEL_ZERO;
        if (key_jump_s && jump_armed_r) begin
          vy_next_s    = JUMP_V;
          armed_next_s = 1'b0;
          state_next_s = RISE;
        end else if (key_down_s && on_plat_s) begin
          drop_next_s  = DROP_INIT;
          state_next_s = FALL;
        end else if (no_support_s) begin
          state_next_s = FALL;
        end else begin
          state_next_s = GROUNDED;
        end
      end
      RISE: begin
        // Releasing jump early caps the upward speed before gravity is applied.
        if (!key_jump_s && (vy_r < CUT_V)) begin
          vy_next_s = CUT_V + GRAV_V;
        end else begin
          vy_next_s = vy_grav_s;
        end
        if (vy_next_s >= VEL_ZERO) begin
          state_next_s = FALL;
        end else begin
          state_next_s = RISE;
        end
      end
      FALL: begin
        if (vy_grav_s > MAX_FALL_V) begin
          vy_next_s = MAX_FALL_V;
        end else begin
          vy_next_s = vy_grav_s;
        end
      end
      default: begin
        vy_next_s    = VEL_ZERO;
        state_next_s = GROUNDED;
      end
    endcase

    y_sum_s = y_ext_s + SUM_W'(vy_next_s);
    y_new_s = y_sum_s[POS_W-1:0];
    if (state_next_s == RISE) begin
      if (y_sum_s < Y_TOP_SUB) begin
        y_new_s      = Y_TOP_SUB[POS_W-1:0];
        vy_next_s    = VEL_ZERO;
        state_next_s = FALL;
      end else begin
        y_new_s = y_sum_s[POS_W-1:0];
      end
    end else if (state_next_s == FALL) begin
      // One-way platform: only a downward crossing of its top surface lands.
      if ((drop_cnt_r == {DROP_W{1'b0}}) && overlap_new_s &&
          (y_ext_s <= Y_PLAT_SUB) && (y_sum_s > Y_PLAT_SUB)) begin
        y_new_s      = Y_PLAT_SUB[POS_W-1:0];
        vy_next_s    = VEL_ZERO;
        state_next_s = GROUNDED;
      end else if (y_sum_s > Y_BOT_SUB) begin
        y_new_s      = Y_BOT_SUB[POS_W-1:0];
        vy_next_s    = VEL_ZERO;
        state_next_s = GROUNDED;
      end else begin
        y_new_s = y_sum_s[POS_W-1:0];
      end
    end else begin
      y_new_s = y_sum_s[POS_W-1:0];
    end
  end

  // Frame state registers.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_r           <= POS_W'(X_START <<< FRAC);
      y_r           <= Y_PLAT_SUB[POS_W-1:0];
      vy_r          <= VEL_ZERO;
      state_r       <= GROUNDED;
      facing_left_r <= 1'b0;
      jump_armed_r  <= 1'b1;
      drop_cnt_r    <= {DROP_W{1'b0}};
    end else begin
      x_r           <= x_new_s;
      y_r           <= y_new_s;
      vy_r          <= vy_next_s;
      state_r       <= state_next_s;
      facing_left_r <= facing_next_s;
      jump_armed_r  <= armed_next_s;
      drop_cnt_r    <= drop_next_s;
    end
  end

  assign PlayerX     = x_r[POS_W-1:FRAC];
  assign PlayerY     = y_r[POS_W-1:FRAC];
  assign PlayerSX    = 10'(SIZE_X);
  assign PlayerSY    = 10'(SIZE_Y);
  assign facing_left = facing_left_r;
  assign on_ground   = (state_r == GROUNDED);
  assign state       = state_r;

endmodule

// File: tb/tb_player_physics.sv
// Bench for player_physics: stimulus pushes the reference model's expected
// outputs into a queue; a monitor pops and compares after every frame update
// and after each asynchronous reset assertion.
module tb_player_physics;

  logic        frame_clk = 1'b0;
  logic        Reset_n   = 1'b1;
  logic [15:0] keycode   = 16'h0000;
  logic [9:0]  PlayerX, PlayerY, PlayerSX, PlayerSY;
  logic        facing_left, on_ground;
  logic [1:0]  state;

  player_physics #(.NUM_KEYS(2)) dut (
    .frame_clk   (frame_clk),
    .Reset_n     (Reset_n),
    .keycode     (keycode),
    .PlayerX     (PlayerX),
    .PlayerY     (PlayerY),
    .PlayerSX    (PlayerSX),
    .PlayerSY    (PlayerSY),
    .facing_left (facing_left),
    .on_ground   (on_ground),
    .state       (state)
  );

  always #5 frame_clk = ~frame_clk;

  localparam logic [15:0] K_NONE  = 16'h0000;
  localparam logic [15:0] K_LEFT  = 16'h0050;
  localparam logic [15:0] K_RIGHT = 16'h004F;
  localparam logic [15:0] K_DOWN  = 16'h0051;
  localparam logic [15:0] K_JUMP  = 16'h5200;
  localparam logic [15:0] K_LR    = 16'h4F50;

  // Reference model in sub-pixels (16 per px); y is the centre, edges derived from size.
  localparam int SUB = 16;
  localparam int HW  = 14 * SUB;  // half width
  localparam int HH  = 31 * SUB;  // half height

  typedef struct { int x; int y; bit face; bit gnd; int st; } exp_t;
  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  int mx, my, mvy, mst, mdrop;
  bit mface, marmed;

  function automatic bit has_key(input logic [15:0] kc, input logic [7:0] k);
    return (kc[7:0] == k) || (kc[15:8] == k);
  endfunction

  function automatic bit plat_overlap(input int x);
    return ((x + HW) >= 116 * SUB) && ((x - HW) <= 523 * SUB);
  endfunction

  task automatic model_reset();
    mx = 320 * SUB; my = 377 * SUB; mvy = 0; mst = 0;
    mface = 1'b0; marmed = 1'b1; mdrop = 0;
  endtask

  task automatic model_step(input logic [15:0] kc);
    bit l, r, d, j, nface, narmed;
    int vx, nvy, nst, nx, ny, ndrop;
    l = has_key(kc, 8'h50); r = has_key(kc, 8'h4F);
    d = has_key(kc, 8'h51); j = has_key(kc, 8'h52);
    vx = 0; nface = mface;
    if (l && !r) begin vx = -32; nface = 1'b1; end
    if (r && !l) begin vx = 32; nface = 1'b0; end
    narmed = j ? marmed : 1'b1;
    ndrop  = (mdrop > 0) ? mdrop - 1 : 0;
    nvy = mvy; nst = mst;
    if (mst == 0) begin
      nvy = 0;
      if (j && marmed) begin
        nvy = -128; narmed = 1'b0; nst = 1;
      end else if (d && plat_overlap(mx) && (my + HH == 408 * SUB)) begin
        ndrop = 8; nst = 2;
      end else if (!plat_overlap(mx) && (my + HH < 451 * SUB)) begin
        nst = 2;
      end
    end else if (mst == 1) begin
      if (!j && nvy < -32) nvy = -32;
      nvy = nvy + 8;
      if (nvy >= 0) nst = 2;
    end else begin
      nvy = (mvy + 8 > 96) ? 96 : mvy + 8;
    end
    nx = mx + vx;
    if (nx - HW < 31 * SUB)  nx = 31 * SUB + HW;
    if (nx + HW > 607 * SUB) nx = 607 * SUB - HW;
    ny = my + nvy;
    if (nst == 1 && (ny - HH < 100 * SUB)) begin
      ny = 100 * SUB + HH; nvy = 0; nst = 2;
    end else if (nst == 2) begin
      if ((my + HH <= 408 * SUB) && (ny + HH > 408 * SUB) && plat_overlap(nx) && mdrop == 0) begin
        ny = 408 * SUB - HH; nvy = 0; nst = 0;
      end else if (ny + HH > 451 * SUB) begin
        ny = 451 * SUB - HH; nvy = 0; nst = 0;
      end
    end
    mx = nx; my = ny; mvy = nvy; mst = nst;
    mface = nface; marmed = narmed; mdrop = ndrop;
  endtask

  task automatic push_exp();
    exp_t e;
    e.x = mx / SUB; e.y = my / SUB; e.face = mface; e.gnd = (mst == 0); e.st = mst;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a falling edge: drive keys for the next update and record the expectation.
  task automatic frame(input logic [15:0] kc);
    keycode = kc;
    model_step(kc);
    push_exp();
    @(negedge frame_clk);
  endtask

  task automatic frames(input logic [15:0] kc, input int n);
    for (int i = 0; i < n; i++) frame(kc);
  endtask

  // Reset asserted between edges: the outputs must take reset values at once and hold across an edge.
  task automatic do_reset();
    keycode = K_NONE;
    model_reset();
    push_exp();
    push_exp();
    Reset_n = 1'b0;
    #1;
    chk("async_reset_x", int'(PlayerX), 320);
    chk("async_reset_y", int'(PlayerY), 377);
    @(negedge frame_clk);
    Reset_n = 1'b1;
  endtask

  // Monitor: compare DUT outputs with the oldest expectation after each update.
  initial begin
    exp_t e;
    forever begin
      @(posedge frame_clk or negedge Reset_n);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if (int'(PlayerX) != e.x || int'(PlayerY) != e.y || facing_left != e.face ||
            on_ground != e.gnd || int'(state) != e.st) begin
          n_bad++;
          $display("FAIL frame_vec @%0t: got X=%0d Y=%0d face=%0d gnd=%0d st=%0d, expected X=%0d Y=%0d face=%0d gnd=%0d st=%0d",
                   $time, PlayerX, PlayerY, facing_left, on_ground, state,
                   e.x, e.y, e.face, e.gnd, e.st);
        end
      end
    end
  end

  initial begin
    int ymin, hold;
    logic [15:0] kc;
    logic [7:0] ktab [6];
    ktab[0] = 8'h00; ktab[1] = 8'h50; ktab[2] = 8'h4F;
    ktab[3] = 8'h51; ktab[4] = 8'h52; ktab[5] = 8'h04;

    @(negedge frame_clk);
    do_reset();

    // Idle after reset.
    frames(K_NONE, 10);
    chk("idle_x", int'(PlayerX), 320);
    chk("idle_y", int'(PlayerY), 377);
    chk("idle_on_ground", int'(on_ground), 1);
    chk("idle_state", int'(state), 0);
    chk("size_x", int'(PlayerSX), 28);
    chk("size_y", int'(PlayerSY), 62);

    // Walking.
    frames(K_RIGHT, 5);
    chk("right5_x", int'(PlayerX), 330);
    chk("right5_facing", int'(facing_left), 0);
    frames(K_LR, 3);
    chk("both_keys_x", int'(PlayerX), 330);

    // Full-height jump with the key held throughout.
    frames(K_JUMP, 16);
    chk("apex_y", int'(PlayerY), 309);
    chk("apex_state", int'(state), 1);
    frame(K_JUMP);
    chk("after_apex_state", int'(state), 2);
    frames(K_JUMP, 30);
    chk("landed_y", int'(PlayerY), 377);
    chk("landed_state", int'(state), 0);
    frames(K_JUMP, 3);
    chk("no_rejump_state", int'(state), 0);

    // Tapped jump: upward speed is cut after one frame.
    do_reset();
    frame(K_NONE);
    frame(K_JUMP);
    ymin = 1023;
    for (int i = 0; i < 25; i++) begin
      if (int'(PlayerY) < ymin) ymin = int'(PlayerY);
      frame(K_NONE);
    end
    chk("tap_apex", ymin, 366);
    chk("tap_apex_window", int'(ymin > 309 && ymin < 377), 1);
    chk("tap_landed_y", int'(PlayerY), 377);

    // Walk off the right end of the platform onto the arena floor.
    do_reset();
    frames(K_RIGHT, 115);
    frames(K_NONE, 15);
    chk("walkoff_y", int'(PlayerY), 420);
    chk("walkoff_state", int'(state), 0);

    // Drop through the platform.
    do_reset();
    frame(K_DOWN);
    chk("drop_state", int'(state), 2);
    frames(K_NONE, 20);
    chk("drop_y", int'(PlayerY), 420);

    // Reset while rising.
    do_reset();
    frames(K_JUMP, 5);
    chk("midrise_state", int'(state), 1);
    do_reset();
    chk("midrise_reset_state", int'(state), 0);

    // Left wall clamp.
    frames(K_LEFT, 200);
    chk("left_clamp_x", int'(PlayerX), 45);
    chk("left_facing", int'(facing_left), 1);

    // Randomized key sequences held for a few frames each.
    hold = 0;
    kc = K_NONE;
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin
        kc = {ktab[$urandom_range(0, 5)], ktab[$urandom_range(0, 5)]};
        hold = $urandom_range(1, 8);
      end
      hold--;
      frame(kc);
    end

    @(posedge frame_clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
